// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared display constants, timing defaults and swap-state type
package vga_timing_pkg;
   localparam int unsigned FB_WIDTH  = 800;
   localparam int unsigned FB_HEIGHT = 480;
   localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   localparam int unsigned DEF_H_ACTIVE = FB_WIDTH;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 48;
   localparam int unsigned DEF_H_BP     = 40;
   localparam int unsigned DEF_V_ACTIVE = FB_HEIGHT;
   localparam int unsigned DEF_V_FP     = 13;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BP     = 29;
   localparam logic        DEF_SYNC_POL = 1'b0;

   localparam int unsigned AXIS_W     = 10;
   localparam int unsigned AXIS_LIMIT = 1 << AXIS_W;

   function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   typedef enum logic [0:0] {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_t;
endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrap counter with combinational next value and carry out
module vga_axis_counter #(
   parameter int unsigned W   = 10,
   parameter int unsigned MAX = 927
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] nxt,
   output logic         carry
);
   assign carry = en && (count == W'(MAX));

   always_comb begin
      nxt = count;
      if (en) nxt = carry ? '0 : count + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) count <= '0;
      else       count <= nxt;
   end
endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with vblank-aligned framebuffer swap
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        SYNC_POL = DEF_SYNC_POL
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              pix_en,
   input  logic              swap_req,
   output logic [AXIS_W-1:0] sx,
   output logic [AXIS_W-1:0] sy,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start,
   output logic              vblank,
   output logic              fb_sel,
   output logic              swap_ack
);
   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > AXIS_LIMIT || V_TOTAL > AXIS_LIMIT) begin : g_size_check
      $error("vga_timing: line or frame total exceeds counter range");
   end

   localparam logic [AXIS_W-1:0] H_ACT_L  = AXIS_W'(H_ACTIVE);
   localparam logic [AXIS_W-1:0] HS_START = AXIS_W'(H_ACTIVE + H_FP);
   localparam logic [AXIS_W-1:0] HS_END   = AXIS_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [AXIS_W-1:0] V_ACT_L  = AXIS_W'(V_ACTIVE);
   localparam logic [AXIS_W-1:0] VS_START = AXIS_W'(V_ACTIVE + V_FP);
   localparam logic [AXIS_W-1:0] VS_END   = AXIS_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [AXIS_W-1:0] x_nxt, y_nxt;
   logic              x_carry, y_carry;
   logic              hs_on, vs_on, de_nxt, vb_nxt, swap_point;
   swap_state_t       state;

   vga_axis_counter #(.W(AXIS_W), .MAX(H_TOTAL - 1)) u_x (
      .clk(clk), .rstn(rstn), .en(pix_en),
      .count(sx), .nxt(x_nxt), .carry(x_carry)
   );

   vga_axis_counter #(.W(AXIS_W), .MAX(V_TOTAL - 1)) u_y (
      .clk(clk), .rstn(rstn), .en(x_carry),
      .count(sy), .nxt(y_nxt), .carry(y_carry)
   );

   // Decode from the next position so the registered flags line up with sx/sy.
   assign hs_on      = (x_nxt >= HS_START) && (x_nxt < HS_END);
   assign vs_on      = (y_nxt >= VS_START) && (y_nxt < VS_END);
   assign de_nxt     = (x_nxt < H_ACT_L) && (y_nxt < V_ACT_L);
   assign vb_nxt     = (y_nxt >= V_ACT_L);
   assign swap_point = x_carry && (y_nxt == V_ACT_L);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
         fb_sel      <= 1'b0;
         state       <= SWAP_IDLE;
      end else begin
         frame_start <= y_carry;
         swap_ack    <= 1'b0;
         if (pix_en) begin
            hsync  <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync  <= vs_on ? SYNC_POL : ~SYNC_POL;
            de     <= de_nxt;
            vblank <= vb_nxt;
         end
         // Swap only at the first vblank pixel; a dropped request cancels.
         case (state)
            SWAP_IDLE: begin
               if (swap_req) state <= SWAP_PENDING;
            end
            SWAP_PENDING: begin
               if (!swap_req) begin
                  state <= SWAP_IDLE;
               end else if (swap_point) begin
                  fb_sel   <= ~fb_sel;
                  swap_ack <= 1'b1;
                  state    <= SWAP_IDLE;
               end
            end
            default: state <= SWAP_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing on a reduced raster
module tb_vga_timing;
   // 15 x 10 raster: hsync active sx 10..12, vsync active sy 7..8, 150 pixels per frame
   localparam int HT = 15;
   localparam int VA = 6;
   localparam int FRAME = 150;

   typedef struct packed {
      logic [9:0] sx;
      logic [9:0] sy;
      logic hs, vs, de, vb, fs, fb, ack;
   } obs_t;

   typedef struct {
      int x;
      int y;
      int fb;
      int c;
   } ack_t;

   logic clk = 1'b0;
   logic rstn, pix_en, swap_req;
   logic [9:0] sx, sy;
   logic hsync, vsync, de, frame_start, vblank, fb_sel, swap_ack;

   int checks = 0, errors = 0, pops = 0, pushes = 0, cyc = 0;
   int hs_low = 0, de_hi = 0;
   logic count_line = 1'b0;
   obs_t exp_q[$];
   int fs_times[$];
   ack_t ack_log[$];

   obs_t m;
   int n;
   logic m_pend;

   vga_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rstn(rstn), .pix_en(pix_en), .swap_req(swap_req),
      .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
      .frame_start(frame_start), .vblank(vblank), .fb_sel(fb_sel), .swap_ack(swap_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      n = 0;
      m_pend = 1'b0;
      m = '{sx: 10'd0, sy: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, vb: 1'b0,
            fs: 1'b0, fb: 1'b0, ack: 1'b0};
   endtask

   task automatic step(input logic pe, input logic rq);
      int x, y;
      pix_en = pe;
      swap_req = rq;
      @(posedge clk);
      #1;
      m.fs = 1'b0;
      m.ack = 1'b0;
      if (pe) begin
         n = (n + 1) % FRAME;
         x = n % HT;
         y = n / HT;
         m.sx = 10'(x);
         m.sy = 10'(y);
         m.hs = (x >= 10 && x <= 12) ? 1'b0 : 1'b1;
         m.vs = (y >= 7 && y <= 8) ? 1'b0 : 1'b1;
         m.de = (x < 8 && y < 6);
         m.vb = (y >= 6);
         m.fs = (n == 0);
      end
      if (m_pend) begin
         if (!rq) m_pend = 1'b0;
         else if (pe && n == VA * HT) begin
            m.fb = ~m.fb;
            m.ack = 1'b1;
            m_pend = 1'b0;
         end
      end else if (rq) begin
         m_pend = 1'b1;
      end
      exp_q.push_back(m);
      pushes++;
   endtask

   task automatic run_to(input string name, input int x, input int y);
      int k;
      k = 0;
      while (!(int'(m.sx) == x && int'(m.sy) == y) && k < 2000) begin
         step(1'b1, 1'b0);
         k++;
      end
      if (k >= 2000) check(name, k, -1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sx"}, int'(sx), 0);
      check({tag, "_sy"}, int'(sy), 0);
      check({tag, "_hsync"}, int'(hsync), 1);
      check({tag, "_vsync"}, int'(vsync), 1);
      check({tag, "_de"}, int'(de), 0);
      check({tag, "_vblank"}, int'(vblank), 0);
      check({tag, "_frame_start"}, int'(frame_start), 0);
      check({tag, "_fb_sel"}, int'(fb_sel), 0);
      check({tag, "_swap_ack"}, int'(swap_ack), 0);
   endtask

   always @(negedge clk) begin : monitor
      obs_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{sx: sx, sy: sy, hs: hsync, vs: vsync, de: de, vb: vblank,
               fs: frame_start, fb: fb_sel, ack: swap_ack};
         pops++;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t actual sx=%0d sy=%0d hs=%b vs=%b de=%b vb=%b fs=%b fb=%b ack=%b required sx=%0d sy=%0d hs=%b vs=%b de=%b vb=%b fs=%b fb=%b ack=%b",
                     $time, a.sx, a.sy, a.hs, a.vs, a.de, a.vb, a.fs, a.fb, a.ack,
                     e.sx, e.sy, e.hs, e.vs, e.de, e.vb, e.fs, e.fb, e.ack);
         end
         if (frame_start) fs_times.push_back(cyc);
         if (swap_ack) ack_log.push_back('{x: int'(sx), y: int'(sy), fb: int'(fb_sel), c: cyc});
         if (count_line && sy == 10'd2) begin
            if (!hsync) hs_low++;
            if (de) de_hi++;
         end
      end
   end

   initial begin
      int raise_cyc;
      logic rq;
      pix_en = 1'b0;
      swap_req = 1'b0;
      rstn = 1'b1;
      model_reset();
      #2 rstn = 1'b0;
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rstn = 1'b1;

      // Free-running: period, line widths
      count_line = 1'b1;
      for (int k = 0; k < FRAME; k++) step(1'b1, 1'b0);
      count_line = 1'b0;
      for (int k = 0; k < FRAME + 5; k++) step(1'b1, 1'b0);
      @(negedge clk);
      check("hsync_low_per_line", hs_low, 3);
      check("de_high_per_line", de_hi, 8);
      check("frame_start_count", fs_times.size(), 2);
      if (fs_times.size() >= 2) begin
         check("frame_start_first_cycle", fs_times[0] - (fs_times[1] - FRAME), 0);
         check("frame_period", fs_times[1] - fs_times[0], 150);
      end

      // Request raised in active video, dropped right after the ack
      run_to("reach_3_2", 3, 2);
      ack_log.delete();
      for (int k = 0; k < 400 && !m.ack; k++) step(1'b1, 1'b1);
      for (int k = 0; k < 200; k++) step(1'b1, 1'b0);
      @(negedge clk);
      check("ack_count_active_req", ack_log.size(), 1);
      if (ack_log.size() >= 1) begin
         check("ack_sx_active_req", ack_log[0].x, 0);
         check("ack_sy_active_req", ack_log[0].y, 6);
         check("ack_fb_active_req", ack_log[0].fb, 1);
      end
      check("fb_sel_after_swap", int'(fb_sel), 1);

      // Async reset with a request pending
      run_to("reach_4_3", 4, 3);
      step(1'b1, 1'b1);
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      swap_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      ack_log.delete();
      for (int k = 0; k < FRAME + 20; k++) step(1'b1, 1'b0);
      @(negedge clk);
      check("ack_count_after_reset", ack_log.size(), 0);

      // Request raised just after the first vblank pixel, held until ack
      run_to("reach_5_6", 5, 6);
      ack_log.delete();
      raise_cyc = cyc;
      rq = 1'b1;
      for (int k = 0; k < 400 && !m.ack; k++) step(1'b1, rq);
      for (int k = 0; k < 50; k++) step(1'b1, 1'b0);
      @(negedge clk);
      check("ack_count_late_req", ack_log.size(), 1);
      if (ack_log.size() >= 1) begin
         check("ack_delay_late_req", ack_log[0].c - raise_cyc, 145);
         check("ack_sx_late_req", ack_log[0].x, 0);
         check("ack_sy_late_req", ack_log[0].y, 6);
         check("ack_fb_late_req", ack_log[0].fb, 1);
      end

      // pix_en one cycle in four
      fs_times.delete();
      for (int k = 0; k < 1300; k++) step((k % 4) == 0, 1'b0);
      @(negedge clk);
      check("frame_start_count_slow", fs_times.size() >= 2 ? 1 : 0, 1);
      if (fs_times.size() >= 2) check("frame_period_slow", fs_times[1] - fs_times[0], 600);

      @(negedge clk);
      check("scoreboard_drained", pops, pushes);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 800 visible pixels/line; H_FP 40 front porch; H_SYNC 48 sync width; H_BP 40 back porch (H total 928); V_ACTIVE 480 visible lines; V_FP 13; V_SYNC 3; V_BP 29 (V total 525); SYNC_POL 0, where 0 means the sync pulse is active-low.
REQ-002 clk  in  1  system clock; the only clock.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 pix_en  in  1  pixel strobe; counters advance only on cycles where pix_en=1.
REQ-005 swap_req  in  1  level request from the renderer to flip framebuffers; held high until swap_ack.
REQ-006 sx  out  10  current horizontal position, 0..927.
REQ-007 sy  out  10  current vertical position, 0..524.
REQ-008 hsync  out  1  horizontal sync.
REQ-009 vsync  out  1  vertical sync.
REQ-010 de  out  1  data enable; 1 when sx<H_ACTIVE and sy<V_ACTIVE.
REQ-011 frame_start  out  1  single-cycle pulse when the position becomes (0,0).
REQ-012 vblank  out  1  1 when sy>=V_ACTIVE.
REQ-013 fb_sel  out  1  framebuffer currently being scanned out.
REQ-014 swap_ack  out  1  single-cycle pulse when a swap is accepted.

Function
REQ-015 All outputs shall be registered, with zero combinational paths from inputs to outputs.
REQ-016 On each cycle with pix_en=1, sx shall increment, wrap to 0 after H total-1, and increment sy on wrap.
REQ-017 sy shall wrap from V total-1 to 0 on the same cycle that sx wraps.
REQ-018 With pix_en=0, sx, sy, hsync, vsync, de, vblank and fb_sel shall hold, and frame_start and swap_ack shall be 0.
REQ-019 hsync shall be active while H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (sx 840..887 with defaults).
REQ-020 vsync shall be active while V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (sy 493..495 with defaults).
REQ-021 hsync, vsync, de and vblank shall be decoded from the same sx/sy values being output, so every output is aligned to the same pixel.
REQ-022 frame_start shall be 1 exactly on the pix_en cycle on which sx and sy are loaded with 0,0.
REQ-023 The swap FSM shall have two states: IDLE and PENDING.
REQ-024 IDLE shall go to PENDING when swap_req=1.
REQ-025 PENDING shall take the swap on the pix_en cycle on which the position becomes (0,V_ACTIVE): fb_sel toggles, swap_ack pulses for 1 cycle, and the FSM returns to IDLE.
REQ-026 A request arriving after the first vblank pixel shall wait for the next frame, so at most one swap occurs per frame.
REQ-027 If swap_req drops while PENDING, the request shall be cancelled and the FSM shall return to IDLE with no ack.
REQ-028 If swap_req is still high in the cycle after swap_ack, it shall be treated as a new request.
REQ-029 fb_sel shall never change while de=1.
REQ-030 Counter widths shall be 10 bits; the block shall fail elaboration if H total or V total exceeds 1024.

Reset
REQ-031 rstn low shall immediately set: sx=0, sy=0, de=0, vblank=0, hsync and vsync inactive, frame_start=0, swap_ack=0, fb_sel=0, and FSM=IDLE.
REQ-032 After rstn release, the first pix_en cycle shall advance the position to (1,0); no frame_start pulse is issued for the reset position.
REQ-033 Reset asserted mid-swap shall discard the pending request.

Structure
REQ-034 The timing defaults, the derived totals and the swap-state enum shall live in the shared display package, next to the framebuffer size constants.
REQ-035 One sub-module, vga_axis_counter (parameterised wrap counter with carry out), shall be instantiated twice, once for x and once for y.

Verification
REQ-036 Free-running with pix_en=1 from reset: frame period = 928*525 = 487200 cycles; frame_start pulses are exactly that many cycles apart.
REQ-037 Over one line: hsync is low for exactly 48 cycles starting at sx=840; de is high for exactly 800 cycles.
REQ-038 pix_en toggling 1 cycle in 4: outputs step only on enabled cycles; the frame period is 4*487200 cycles.
REQ-039 swap_req raised at (100,200): swap_ack is seen once at (0,480), fb_sel flips, and no further ack follows while swap_req is dropped after the ack.
REQ-040 swap_req raised at (5,480) and held: no ack this frame; ack at the next (0,480).
REQ-041 rstn pulsed low at (400,300) with a swap pending: all outputs return to reset values asynchronously, and no ack follows unless swap_req is re-raised.
